sync_debounce: RTL

Input conditioning stage that sits directly upstream of the team's `dff` block and drives its `d` input. It takes an asynchronous, possibly bouncing input and passes it through a multi-flop synchronizer. The synchronized level is accepted only after it has been stable for a programmable number of cycles. The block outputs the clean level, its complement, and single-cycle rise and fall pulses.

---
 rtl/sync_debounce.sv | 51 +++++
 1 files changed

// File: rtl/sync_debounce.sv
// sync_debounce: synchronizes an asynchronous input and debounces it into a clean level with rise/fall pulses
module sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic qb,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   q_q, q_d, rise_q, rise_d, fall_q, fall_d;
  logic                   s, diff, done;
  // Shift din into the synchronizer; count consecutive disagreements and commit once the run completes
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    s      = sync_q[SYNC_STAGES-1];
    diff   = s ^ q_q;
    done   = diff && (cnt_q == LAST);
    cnt_d  = (diff && !done) ? cnt_q + CW'(1) : '0;
    q_d    = done ? s : q_q;
    rise_d = done & s;
    fall_d = done & ~s;
  end
  // State registers; asynchronous assertion of the active-low reset clears everything at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      q_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign q    = q_q;
  assign qb   = ~q_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule
